// File: rtl/ilk_cmd_arbiter_pkg.sv
// Shared types, sizes and pair/port mapping helpers for the 8-port interlock arbiter.
package ilk_pkg;

    localparam int NPORT = 8;
    localparam int NPAIR = 28;

    typedef enum logic [1:0] {
        OP_NOP        = 2'd0,
        OP_CONNECT    = 2'd1,
        OP_DISCONNECT = 2'd2,
        OP_CLEAR_ALL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_CONFLICT = 2'd1,
        RSP_BADARG   = 2'd2,
        RSP_NOTCONN  = 2'd3
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef logic [1:NPORT] port_vec_t;
    typedef logic [1:NPAIR] pair_vec_t;

    // Ports are 1-based and order-insensitive; the result is 1..28 for distinct ports.
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return ((hi - 1) * (hi - 2)) / 2 + lo;
    endfunction

    function automatic port_vec_t ports_of_pair(input int idx);
        port_vec_t m;
        m = '0;
        for (int j = 2; j <= NPORT; j++) begin
            for (int i = 1; i < j; i++) begin
                if (pair_idx(i, j) == idx) begin
                    m[i] = 1'b1;
                    m[j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ilk_cmd_arbiter_if.sv
// Command/response bundle between a command source and ilk_cmd_arbiter.
interface ilk_cmd_arbiter_if;
    import ilk_pkg::*;

    // A command transfers on a rising edge where cmd_valid && cmd_ready; the sender holds
    // cmd_op/cmd_a/cmd_b stable while cmd_valid is high, and cmd_valid with cmd_ready low
    // is ignored. rsp_valid is a one-cycle strobe with no back-pressure.
    logic      cmd_valid;
    logic      cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic      rsp_valid;
    logic [1:0] rsp_code;
    port_vec_t outP;
    pair_vec_t out;
    state_e    dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready, rsp_valid, rsp_code, outP, out, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready, rsp_valid, rsp_code, outP, out, dbg_state
    );

endinterface

// File: rtl/ilk_cmd_arbiter_pair_decode.sv
// Combinational decode of a (cmd_a, cmd_b) port pair into index, one-hot and port mask.
module ilk_pair_decode
    import ilk_pkg::*;
(
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [4:0] o_idx,
    output pair_vec_t  o_pair_onehot,
    output logic       o_same,
    output port_vec_t  o_port_mask
);

    always_comb begin
        o_same        = (i_a == i_b);
        o_idx         = 5'(pair_idx(int'(i_a) + 1, int'(i_b) + 1));
        o_pair_onehot = '0;
        o_port_mask   = '0;
        if (!o_same) begin
            o_pair_onehot[o_idx] = 1'b1;
            o_port_mask          = ports_of_pair(int'(o_idx));
        end
    end

endmodule

// File: rtl/ilk_cmd_arbiter.sv
// Command arbiter for the 8x8 interlock output stage: owns the pair matrix and hold-off.
// Optional idle auto-clear is enabled by defining ILK_WATCHDOG_EN.
module ilk_cmd_arbiter
    import ilk_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYC = 600000,
    parameter int unsigned WDOG_CYC    = 50000000
) (
    input  logic             pclk_50M,
    input  logic             rst,
    ilk_cmd_arbiter_if.slave bus
);

    localparam int unsigned   HW        = $clog2(HOLDOFF_CYC + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC - 1);

    if (HOLDOFF_CYC < 1 || WDOG_CYC < 1) begin : g_param_check
        $error("ilk_cmd_arbiter: HOLDOFF_CYC and WDOG_CYC must be at least 1");
    end

    state_e        r_state, w_state_nxt;
    op_e           r_op, w_op_nxt;
    logic [2:0]    r_a, r_b, w_a_nxt, w_b_nxt;
    pair_vec_t     r_out, w_out_nxt;
    port_vec_t     r_outP, w_outP_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    rsp_e          r_rsp_code, w_rsp_code_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic          w_changed;
    logic          w_handshake;
    logic          w_wdog_fire;

    logic [4:0]    w_pair_idx;
    pair_vec_t     w_pair_onehot;
    logic          w_same;
    port_vec_t     w_port_mask;
    logic          w_pair_active;
    logic          w_port_busy;

    ilk_pair_decode u_decode (
        .i_a           (r_a),
        .i_b           (r_b),
        .o_idx         (w_pair_idx),
        .o_pair_onehot (w_pair_onehot),
        .o_same        (w_same),
        .o_port_mask   (w_port_mask)
    );

    assign w_pair_active = |(r_out & w_pair_onehot);
    assign w_port_busy   = |(r_outP & w_port_mask);
    assign w_handshake   = bus.cmd_valid && bus.cmd_ready;

    assign bus.cmd_ready = (r_state == ST_IDLE) && !rst;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_code  = r_rsp_code;
    assign bus.outP      = r_outP;
    assign bus.out       = r_out;
    assign bus.dbg_state = r_state;

`ifdef ILK_WATCHDOG_EN
    localparam int unsigned   WW        = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

    logic [WW-1:0] r_idle_cnt;

    // Counts idle cycles with a live matrix; fires on the WDOG_CYC-th such cycle.
    always_ff @(posedge pclk_50M) begin
        if (rst || r_state != ST_IDLE || w_handshake || r_out == '0) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != WDOG_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_wdog_fire = (r_state == ST_IDLE) && !w_handshake &&
                         (r_out != '0) && (r_idle_cnt == WDOG_LAST);
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_out_nxt       = r_out;
        w_outP_nxt      = r_outP;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_code_nxt  = r_rsp_code;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_changed       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_op_nxt    = op_e'(bus.cmd_op);
                    w_a_nxt     = bus.cmd_a;
                    w_b_nxt     = bus.cmd_b;
                    w_state_nxt = ST_CHECK;
                end else if (w_wdog_fire) begin
                    w_op_nxt    = OP_CLEAR_ALL;
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_code_nxt  = RSP_OK;
                case (r_op)
                    OP_CONNECT: begin
                        if (w_same) begin
                            w_rsp_code_nxt = RSP_BADARG;
                        end else if (w_pair_active) begin
                            w_rsp_code_nxt = RSP_OK;
                        end else if (w_port_busy) begin
                            w_rsp_code_nxt = RSP_CONFLICT;
                        end else begin
                            w_out_nxt[w_pair_idx] = 1'b1;
                            w_outP_nxt            = r_outP | w_port_mask;
                            w_changed             = 1'b1;
                        end
                    end
                    OP_DISCONNECT: begin
                        if (w_same) begin
                            w_rsp_code_nxt = RSP_BADARG;
                        end else if (!w_pair_active) begin
                            w_rsp_code_nxt = RSP_NOTCONN;
                        end else begin
                            w_out_nxt[w_pair_idx] = 1'b0;
                            w_outP_nxt            = r_outP & ~w_port_mask;
                            w_changed             = 1'b1;
                        end
                    end
                    OP_CLEAR_ALL: begin
                        w_out_nxt  = '0;
                        w_outP_nxt = '0;
                        w_changed  = |r_out;
                    end
                    default: ;
                endcase
                if (w_changed) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_outP      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= RSP_OK;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_out       <= w_out_nxt;
            r_outP      <= w_outP_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_code  <= w_rsp_code_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ilk_cmd_arbiter.sv
// Randomized scoreboard bench for ilk_cmd_arbiter; the partner-table model predicts responses.
module tb_ilk_cmd_arbiter;

    localparam int unsigned H  = 24;
`ifdef ILK_WATCHDOG_EN
    localparam int unsigned WD = 1000;
`else
    localparam int unsigned WD = 50000000;
`endif
    localparam int EW = 38;

    logic pclk_50M = 1'b0;
    logic rst;

    ilk_cmd_arbiter_if bus();

    ilk_cmd_arbiter #(
        .HOLDOFF_CYC (H),
        .WDOG_CYC    (WD)
    ) dut (
        .pclk_50M (pclk_50M),
        .rst      (rst),
        .bus      (bus)
    );

    // ---------------- clock / timeout ----------------
    always #10 pclk_50M = ~pclk_50M;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int n_checks = 0;
    int n_errors = 0;
    int partner[1:8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pair_of(input int p, input int q);
        return ((q - 1) * (q - 2)) / 2 + p;
    endfunction

    task automatic model_cmd(input int op, input int a, input int b,
                             output logic [1:0] code, output bit changed);
        int i;
        int j;
        i       = a + 1;
        j       = b + 1;
        code    = 2'd0;
        changed = 1'b0;
        case (op)
            1: begin
                if (i == j) code = 2'd2;
                else if (partner[i] == j) code = 2'd0;
                else if (partner[i] != 0 || partner[j] != 0) code = 2'd1;
                else begin
                    partner[i] = j;
                    partner[j] = i;
                    changed    = 1'b1;
                end
            end
            2: begin
                if (i == j) code = 2'd2;
                else if (partner[i] != j) code = 2'd3;
                else begin
                    partner[i] = 0;
                    partner[j] = 0;
                    changed    = 1'b1;
                end
            end
            3: begin
                for (int p = 1; p <= 8; p++) begin
                    if (partner[p] != 0) changed = 1'b1;
                    partner[p] = 0;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [EW-1:0] model_expect(input logic [1:0] code);
        logic [1:8]  p_v;
        logic [1:28] o_v;
        p_v = '0;
        o_v = '0;
        for (int p = 1; p <= 8; p++) begin
            if (partner[p] != 0) begin
                p_v[p] = 1'b1;
                if (partner[p] > p) o_v[pair_of(p, partner[p])] = 1'b1;
            end
        end
        return {code, p_v, o_v};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge pclk_50M) begin
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got rsp code %0d, expected no response", bus.rsp_code);
            end else begin
                e = exp_q.pop_front();
                check("rsp_code", 64'(bus.rsp_code), 64'(e[37:36]));
                check("outP",     64'(bus.outP),     64'(e[35:28]));
                check("out",      64'(bus.out),      64'(e[27:0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_cmd(input int op, input int a, input int b, input bit check_gap);
        logic [1:0] code;
        bit         changed;
        bit         got;
        int         gap;
        got = 1'b0;
        for (int c = 0; c < int'(H) + 200; c++) begin
            @(negedge pclk_50M);
            if (bus.cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: cmd_ready got 0, expected 1");
            return;
        end
        model_cmd(op, a, b, code, changed);
        exp_q.push_back(model_expect(code));
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_a     = 3'(a);
        bus.cmd_b     = 3'(b);
        @(posedge pclk_50M);
        #1;
        bus.cmd_valid = 1'b0;
        if (check_gap) begin
            gap = 0;
            for (int c = 0; c < int'(H) + 50; c++) begin
                @(negedge pclk_50M);
                if (bus.cmd_ready) break;
                gap++;
                // Commands offered while not ready must be ignored.
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_op    = 2'($urandom_range(0, 3));
                bus.cmd_a     = 3'($urandom_range(0, 7));
                bus.cmd_b     = 3'($urandom_range(0, 7));
            end
            bus.cmd_valid = 1'b0;
            check("ready_gap", 64'(gap), 64'(changed ? int'(H) + 1 : 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op;
        int a;
        int b;
        int r;
        int waited;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 3'd0;
        bus.cmd_b     = 3'd0;
        rst           = 1'b1;
        for (int p = 1; p <= 8; p++) partner[p] = 0;

        repeat (3) @(posedge pclk_50M);
        @(negedge pclk_50M);
        check("reset_ready",     64'(bus.cmd_ready), 64'd0);
        check("reset_out",       64'(bus.out),       64'd0);
        check("reset_outP",      64'(bus.outP),      64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_code",  64'(bus.rsp_code),  64'd0);
        rst = 1'b0;
        @(negedge pclk_50M);
        check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        // Directed cases
        send_cmd(1, 0, 1, 1);   // connect (1,2): hold-off
        send_cmd(1, 1, 4, 1);   // (2,5): conflict
        send_cmd(1, 1, 0, 1);   // (2,1) already active: OK, no hold
        send_cmd(0, 5, 2, 1);   // NOP
        send_cmd(1, 7, 6, 1);   // (8,7)
        send_cmd(2, 6, 7, 1);   // disconnect (7,8)
        send_cmd(1, 3, 3, 1);   // badarg
        send_cmd(2, 2, 4, 1);   // (3,5) inactive: notconn
        send_cmd(2, 5, 5, 1);   // badarg
        send_cmd(1, 2, 3, 1);   // (3,4)
        send_cmd(1, 4, 5, 1);   // (5,6)
        send_cmd(1, 6, 7, 1);   // (7,8)
        send_cmd(3, 0, 0, 1);   // clear all four pairs
        send_cmd(3, 0, 0, 1);   // clear of empty matrix: no hold

        // Random commands, biased toward hitting live pairs on disconnect
        repeat (50) begin
            r = int'($urandom_range(0, 9));
            op = (r < 5) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            if (op == 2 && partner[a + 1] != 0 && $urandom_range(0, 1) == 1) b = partner[a + 1] - 1;
            send_cmd(op, a, b, 1);
        end
        send_cmd(3, 0, 0, 1);

        // Reset in the middle of a hold-off
        send_cmd(1, 0, 7, 0);
        repeat (5) @(negedge pclk_50M);
        check("hold_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b1;
        for (int p = 1; p <= 8; p++) partner[p] = 0;
        repeat (2) @(negedge pclk_50M);
        check("hold_reset_ready", 64'(bus.cmd_ready), 64'd0);
        check("hold_reset_out",   64'(bus.out),       64'd0);
        check("hold_reset_outP",  64'(bus.outP),      64'd0);
        rst = 1'b0;
        @(negedge pclk_50M);
        check("ready_after_hold_reset", 64'(bus.cmd_ready), 64'd1);

`ifdef ILK_WATCHDOG_EN
        begin
            logic [1:0] wcode;
            bit         wchanged;
            send_cmd(1, 0, 7, 1);   // (1,8), then stay idle
            model_cmd(3, 0, 0, wcode, wchanged);
            exp_q.push_back(model_expect(wcode));
            waited = 0;
            for (int c = 0; c < int'(WD) + int'(H) + 100; c++) begin
                @(negedge pclk_50M);
                waited++;
                if (exp_q.size() == 0) break;
            end
            check("wdog_fired", 64'(exp_q.size()), 64'd0);
            check("wdog_timing", 64'(waited >= int'(WD) && waited <= int'(WD) + 3), 64'd1);
        end
`endif

        waited = 0;
        repeat (4) @(negedge pclk_50M);
        check("queue_drained", 64'(exp_q.size()), 64'(waited));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
